aes_enc_sched: RTL and testbench

Sequencer and round-robin arbiter that shares one combinational aes_encryptor between two requesters. It holds the 128-bit key register and latches the granted plaintext onto the encryptor inputs. It waits a fixed number of settle cycles (multicycle path through the combinational core), then captures the ciphertext and returns it with a requester id over a valid/ready response channel. It sits between the system request interfaces and the aes_encryptor instance.

---
 rtl/aes_enc_sched.sv | 105 ++++++++++
 tb/tb_aes_enc_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_sched.sv
// Round-robin sequencer that time-shares one combinational AES-128 core between
// two requesters, holding its inputs stable for SETTLE_CYCLES before capture.
module aes_enc_sched #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal 1..15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_data,
  output logic         key_ready,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  output logic [127:0] aes_plain_text,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_cipher_text,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]   r_state;
  logic [127:0] r_key;
  logic [127:0] r_pt;
  logic [127:0] r_rsp_data;
  logic         r_rsp_id;
  logic         r_rsp_valid;
  logic [3:0]   r_cnt;
  logic         r_last_grant;

  logic w_idle;
  logic w_grant;
  logic w_accept;

  // A tie goes to the requester that did not win last; otherwise the lone valid one.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_grant  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept = w_idle && !key_load && (req0_valid || req1_valid);

  assign key_ready  = w_idle;
  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept &&  w_grant;

  assign aes_key        = r_key;
  assign aes_plain_text = r_pt;
  assign rsp_data       = r_rsp_data;
  assign rsp_id         = r_rsp_id;
  assign rsp_valid      = r_rsp_valid;

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_key        <= '0;
      r_pt         <= '0;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (key_load) begin
            r_key <= key_data;
          end else if (w_accept) begin
            r_pt         <= w_grant ? req1_data : req0_data;
            r_rsp_id     <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= CNT_INIT;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Core inputs have been stable SETTLE_CYCLES cycles when cnt reaches zero.
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_data  <= aes_cipher_text;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_sched.sv
// Directed bench for aes_enc_sched; the encryptor stand-in returns known FIPS-197
// vectors and produces corrupted output until its inputs have settled.
module tb_aes_enc_sched;

  localparam int unsigned S = 2;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_load = 1'b0;
  logic [127:0] key_data = '0;
  logic         key_ready;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [127:0] req0_data = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [127:0] req1_data = '0;
  logic [127:0] aes_plain_text;
  logic [127:0] aes_key;
  logic [127:0] aes_cipher_text = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_id;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;

  aes_enc_sched #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .key_load(key_load), .key_data(key_data), .key_ready(key_ready),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .aes_plain_text(aes_plain_text), .aes_key(aes_key), .aes_cipher_text(aes_cipher_text),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model(input logic [127:0] k, input logic [127:0] p);
    if (k == K1 && p == P1) return C1;
    if (k == K2 && p == P2) return C2;
    return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  // Encryptor stand-in: output is only correct once inputs were stable S cycles.
  logic [127:0] m_prev_key = '0;
  logic [127:0] m_prev_pt  = '0;
  int           m_age      = 0;
  always @(negedge clk) begin
    if (aes_key !== m_prev_key || aes_plain_text !== m_prev_pt) m_age = 1;
    else if (m_age < 100) m_age = m_age + 1;
    m_prev_key = aes_key;
    m_prev_pt  = aes_plain_text;
    aes_cipher_text = (m_age >= int'(S)) ? model(aes_key, aes_plain_text)
                                         : ~model(aes_key, aes_plain_text);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1;
    key_data = k;
    tick();
    key_load = 1'b0;
  endtask

  task automatic accept(input int id, input logic [127:0] d);
    bit ok = 1'b0;
    if (id == 0) begin req0_valid = 1'b1; req0_data = d; end
    else         begin req1_valid = 1'b1; req1_data = d; end
    for (int n = 0; n < 50; n++) begin
      #1;
      if ((id == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!ok) check("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 128'd0, 128'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 128'(rsp_valid), 128'd0);
  endtask

  int           lat;
  int           ng, nr;
  int           g_id [4];
  int           g_cyc[4];
  int           r_id [4];
  logic [127:0] r_dat[4];
  logic [127:0] held_data;
  logic         held_id;

  initial begin
    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_rsp_data", rsp_data, 128'd0);
    check("rst_rsp_id", 128'(rsp_id), 128'd0);
    check("rst_aes_key", aes_key, 128'd0);
    check("rst_aes_pt", aes_plain_text, 128'd0);
    check("rst_key_ready", 128'(key_ready), 128'd1);
    check("rst_req_ready", 128'({req0_ready, req1_ready}), 128'd0);

    // FIPS-197 appendix B vector via requester 0
    load_key(K1);
    check("k1_aes_key", aes_key, K1);
    accept(0, P1);
    check("run_key_ready", 128'(key_ready), 128'd0);
    wait_rsp(lat);
    check("t1_latency", 128'(lat), 128'(S));
    check("t1_rsp_data", rsp_data, C1);
    check("t1_rsp_id", 128'(rsp_id), 128'd0);
    consume();

    // FIPS-197 appendix C.1 vector via requester 1
    load_key(K2);
    accept(1, P2);
    wait_rsp(lat);
    check("t2_latency", 128'(lat), 128'(S));
    check("t2_rsp_data", rsp_data, C2);
    check("t2_rsp_id", 128'(rsp_id), 128'd1);
    consume();

    // Both requesters continuously valid: strict alternation, S+2 spacing
    req0_data = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    req1_data = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready = 1'b1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 200 && nr < 4; c++) begin
      #1;
      if (ng < 4 && (req0_ready || req1_ready)) begin
        g_id[ng]  = int'(req1_ready);
        g_cyc[ng] = cycle;
        ng++;
      end
      tick();
      if (ng == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (rsp_valid) begin
        r_id[nr]  = int'(rsp_id);
        r_dat[nr] = rsp_data;
        nr++;
      end
    end
    tick();
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (nr < 4 || ng < 4) check("rr_timeout", 128'(nr), 128'd4);
    else begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rr_grant%0d", i), 128'(g_id[i]), 128'(i % 2));
        check($sformatf("rr_rsp_id%0d", i), 128'(r_id[i]), 128'(i % 2));
        check($sformatf("rr_rsp_data%0d", i), r_dat[i],
              model(K2, (i % 2 == 0) ? req0_data : req1_data));
        if (i > 0) check($sformatf("rr_spacing%0d", i), 128'(g_cyc[i] - g_cyc[i-1]), 128'(S + 2));
      end
    end
    check("rr_idle_after", 128'(rsp_valid), 128'd0);

    // Stall in DONE: outputs hold, inputs ignored
    accept(0, 128'hdead_beef_0000_1111_2222_3333_4444_5555);
    wait_rsp(lat);
    held_data = rsp_data;
    held_id   = rsp_id;
    check("stall_rsp_data", held_data, model(K2, 128'hdead_beef_0000_1111_2222_3333_4444_5555));
    for (int i = 0; i < 10; i++) begin
      req0_valid = i[0];
      req1_valid = ~i[0];
      req0_data  = {4{$urandom}};
      req1_data  = {4{$urandom}};
      key_load   = 1'b1;
      key_data   = ~K2 ^ 128'(i);
      #1;
      check("stall_readies", 128'({req0_ready, req1_ready, key_ready}), 128'd0);
      tick();
      check("stall_rsp_valid", 128'(rsp_valid), 128'd1);
      check("stall_rsp_data_hold", rsp_data, held_data);
      check("stall_rsp_id", 128'(rsp_id), 128'(held_id));
      check("stall_aes_key", aes_key, K2);
    end
    key_load = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    consume();

    // key_load and req0_valid together: key wins, request follows next cycle
    key_load   = 1'b1;
    key_data   = K1;
    req0_valid = 1'b1;
    req0_data  = P1;
    #1;
    check("kl_req0_ready", 128'(req0_ready), 128'd0);
    check("kl_key_ready", 128'(key_ready), 128'd1);
    tick();
    key_load = 1'b0;
    check("kl_aes_key", aes_key, K1);
    #1;
    check("kl_req0_ready_next", 128'(req0_ready), 128'd1);
    tick();
    req0_valid = 1'b0;
    wait_rsp(lat);
    check("kl_rsp_data", rsp_data, C1);
    consume();

    // Asynchronous reset mid-RUN
    accept(1, P2);
    #3;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("arst_rsp_data", rsp_data, 128'd0);
    check("arst_aes_key", aes_key, 128'd0);
    check("arst_aes_pt", aes_plain_text, 128'd0);
    check("arst_key_ready", 128'(key_ready), 128'd1);
    tick();
    rst = 1'b0;
    load_key(K2);
    req0_valid = 1'b1;
    req0_data  = P2;
    req1_valid = 1'b1;
    req1_data  = P1;
    #1;
    check("arst_tie_grant", 128'({req0_ready, req1_ready}), 128'b10);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(lat);
    check("arst_latency", 128'(lat), 128'(S));
    check("arst_rsp_data", rsp_data, C2);
    check("arst_rsp_id", 128'(rsp_id), 128'd0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
